pwm_multi: RTL and testbench

PWM_MULTI -- requirements
Module: pwm_multi

---
 rtl/pwm_pkg.sv | 13 +
 rtl/pwm_channel.sv | 54 +++++
 rtl/pwm_multi.sv | 156 +++++++++++++++
 tb/tb_pwm_multi.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and types for the multi-channel PWM block.
package pwm_pkg;

    localparam int PWM_N_DEFAULT        = 8;
    localparam int PWM_CHANNELS_DEFAULT = 4;

    // Counting direction, only meaningful in center-aligned operation.
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } pwm_dir_e;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: pending/active duty shadow pair, compare against the
// shared counter, and the registered output.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int N = PWM_N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic [N-1:0] counter,
    input  logic [N-1:0] duty_in,
    input  logic         capture,
    input  logic         apply_new,
    input  logic         apply_pending,
    output logic         out
);

    logic [N-1:0] pending_duty_q, pending_duty_d;
    logic [N-1:0] active_duty_q,  active_duty_d;
    logic         out_q,          out_d;

    // Shadow update and compare; active duty only moves at a wrap (or while
    // disabled), so a cycle in progress always finishes with its old duty.
    always_comb begin
        pending_duty_d = pending_duty_q;
        active_duty_d  = active_duty_q;
        if (capture) begin
            pending_duty_d = duty_in;
        end
        if (apply_new) begin
            active_duty_d = duty_in;
        end else if (apply_pending) begin
            active_duty_d = pending_duty_q;
        end
        out_d = ena & ((active_duty_q == '1) | (counter < active_duty_q));
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_duty_q <= '0;
            active_duty_q  <= '0;
            out_q          <= 1'b0;
        end else begin
            pending_duty_q <= pending_duty_d;
            active_duty_q  <= active_duty_d;
            out_q          <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM with one shared counter and shadowed period/duty.
// Optional feature: define PWM_CENTER_ALIGN_EN to add the `center` input
// and up/down (center-aligned) counting.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int N        = PWM_N_DEFAULT,
    parameter int CHANNELS = PWM_CHANNELS_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic                  step,
    input  logic [N-1:0]          period,
    input  logic [CHANNELS*N-1:0] duty,
    input  logic                  load,
`ifdef PWM_CENTER_ALIGN_EN
    input  logic                  center,
`endif
    output logic [CHANNELS-1:0]   out,
    output logic                  period_start,
    output logic                  update_pending
);

    logic [N-1:0] counter_q,        counter_d;
    logic [N-1:0] active_period_q,  active_period_d;
    logic [N-1:0] pending_period_q, pending_period_d;
    logic         update_pending_q, update_pending_d;
    logic         period_start_q,   period_start_d;
    logic         advance;
    logic         wrap;
    logic         apply_new;
    logic         apply_pending;

    assign advance = ena & step;

`ifdef PWM_CENTER_ALIGN_EN
    pwm_dir_e dir_q, dir_d;

    // Counter sequencing: edge mode wraps after active_period, center mode
    // turns at active_period and wraps on the DOWN step into 0.
    always_comb begin
        counter_d = counter_q;
        dir_d     = dir_q;
        wrap      = 1'b0;
        if (advance) begin
            if (!center || (active_period_q == '0)) begin
                dir_d = DIR_UP;
                if (counter_q >= active_period_q) begin
                    counter_d = '0;
                    wrap      = 1'b1;
                end else begin
                    counter_d = counter_q + 1'b1;
                end
            end else if (dir_q == DIR_UP) begin
                if (counter_q >= active_period_q) begin
                    dir_d     = DIR_DOWN;
                    counter_d = counter_q - 1'b1;
                end else begin
                    counter_d = counter_q + 1'b1;
                end
            end else begin
                if (counter_q <= N'(1)) begin
                    dir_d     = DIR_UP;
                    counter_d = '0;
                    wrap      = 1'b1;
                end else begin
                    counter_d = counter_q - 1'b1;
                end
            end
        end
    end

    // Direction register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dir_q <= DIR_UP;
        end else begin
            dir_q <= dir_d;
        end
    end
`else
    // Counter sequencing: count 0..active_period, then wrap to 0.
    always_comb begin
        counter_d = counter_q;
        wrap      = 1'b0;
        if (advance) begin
            if (counter_q >= active_period_q) begin
                counter_d = '0;
                wrap      = 1'b1;
            end else begin
                counter_d = counter_q + 1'b1;
            end
        end
    end
`endif

    // Shadow control: a load while disabled or coinciding with a wrap goes
    // straight to active; otherwise it parks in pending until the next wrap.
    always_comb begin
        apply_new        = load & (~ena | wrap);
        apply_pending    = wrap & update_pending_q;
        pending_period_d = load ? period : pending_period_q;
        active_period_d  = active_period_q;
        update_pending_d = update_pending_q;
        if (apply_new) begin
            active_period_d  = period;
            update_pending_d = 1'b0;
        end else if (load) begin
            update_pending_d = 1'b1;
        end else if (wrap) begin
            if (update_pending_q) begin
                active_period_d = pending_period_q;
            end
            update_pending_d = 1'b0;
        end
        period_start_d = wrap;
    end

    // Shared state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            counter_q        <= '0;
            active_period_q  <= '0;
            pending_period_q <= '0;
            update_pending_q <= 1'b0;
            period_start_q   <= 1'b0;
        end else begin
            counter_q        <= counter_d;
            active_period_q  <= active_period_d;
            pending_period_q <= pending_period_d;
            update_pending_q <= update_pending_d;
            period_start_q   <= period_start_d;
        end
    end

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            pwm_channel #(.N(N)) u_ch (
                .clk           (clk),
                .rst           (rst),
                .ena           (ena),
                .counter       (counter_q),
                .duty_in       (duty[gi*N +: N]),
                .capture       (load),
                .apply_new     (apply_new),
                .apply_pending (apply_pending),
                .out           (out[gi])
            );
        end
    endgenerate

    assign period_start   = period_start_q;
    assign update_pending = update_pending_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi (N=8, CHANNELS=4).
// Define PWM_CENTER_ALIGN_EN to also exercise center-aligned counting.
module tb_pwm_multi;

    localparam int N  = 8;
    localparam int CH = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            ena;
    logic            step;
    logic [N-1:0]    period;
    logic [CH*N-1:0] duty;
    logic            load;
    logic [CH-1:0]   out;
    logic            period_start;
    logic            update_pending;
`ifdef PWM_CENTER_ALIGN_EN
    logic            center;
`endif

    typedef struct packed {
        logic [CH-1:0] o;
        logic          ps;
        logic          up;
        logic          chk_ps;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   total = 0;
    int   bad   = 0;

    pwm_multi #(.N(N), .CHANNELS(CH)) dut (
        .clk            (clk),
        .rst            (rst),
        .ena            (ena),
        .step           (step),
        .period         (period),
        .duty           (duty),
        .load           (load),
`ifdef PWM_CENTER_ALIGN_EN
        .center         (center),
`endif
        .out            (out),
        .period_start   (period_start),
        .update_pending (update_pending)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [CH-1:0] o, input logic ps, input logic up, input logic chk_ps);
        exp_t x;
        x.o = o; x.ps = ps; x.up = up; x.chk_ps = chk_ps;
        sb.push_back(x);
    endtask

    // Pulse reset between clock edges.
    task automatic do_reset();
        #2 rst = 1'b0;
        #2 rst = 1'b1;
    endtask

    // Load values while disabled so they become active on the next edge.
    task automatic direct_load(input logic [N-1:0] p, input logic [CH*N-1:0] d);
        ena = 1'b0; step = 1'b1; load = 1'b1; period = p; duty = d;
        tick();
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; ena = 1'b0; step = 1'b0; load = 1'b0; period = '0; duty = '0;
`ifdef PWM_CENTER_ALIGN_EN
        center = 1'b0;
`endif
        push(4'b0000, 1'b0, 1'b0, 1'b1);
        tick(); tick();
        e = sb.pop_front();
        total++; if (out !== e.o) begin bad++; $display("FAIL reset_out out=%b expected=%b", out, e.o); end
        total++; if (period_start !== e.ps) begin bad++; $display("FAIL reset_ps ps=%b expected=%b", period_start, e.ps); end
        total++; if (update_pending !== e.up) begin bad++; $display("FAIL reset_up up=%b expected=%b", update_pending, e.up); end
        $display("reset: out=%b ps=%b up=%b", out, period_start, update_pending);
        #2 rst = 1'b1;
    endtask

    // period 9, ch0 duty 3 -> high 3 of 10; period_start every 10 clocks.
    task automatic test_edge_basic();
        logic [CH-1:0] eo;
        do_reset();
        direct_load(8'd9, {8'd5, 8'd255, 8'd0, 8'd3});
        ena = 1'b1; step = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            eo = {(((k-1) % 10) < 5), 1'b1, 1'b0, (((k-1) % 10) < 3)};
            push(eo, (k % 10) == 0, 1'b0, 1'b1);
            tick();
            e = sb.pop_front();
            $display("basic k=%0d out=%b ps=%b up=%b", k, out, period_start, update_pending);
            total++; if (out !== e.o) begin bad++; $display("FAIL basic_out k=%0d out=%b expected=%b", k, out, e.o); end
            total++; if (period_start !== e.ps) begin bad++; $display("FAIL basic_ps k=%0d ps=%b expected=%b", k, period_start, e.ps); end
            total++; if (update_pending !== e.up) begin bad++; $display("FAIL basic_up k=%0d up=%b expected=%b", k, update_pending, e.up); end
        end
    endtask

    // period 255: duty 0 constant low, duty 255 constant high.
    task automatic test_full_scale();
        logic [CH-1:0] eo;
        do_reset();
        direct_load(8'd255, {8'd255, 8'd255, 8'd0, 8'd128});
        ena = 1'b1; step = 1'b1;
        for (int k = 1; k <= 260; k++) begin
            eo = {1'b1, 1'b1, 1'b0, (((k-1) % 256) < 128)};
            push(eo, k == 256, 1'b0, 1'b1);
            tick();
            e = sb.pop_front();
            if (k % 32 == 0) $display("full k=%0d out=%b ps=%b", k, out, period_start);
            total++; if (out !== e.o) begin bad++; $display("FAIL full_out k=%0d out=%b expected=%b", k, out, e.o); end
            total++; if (period_start !== e.ps) begin bad++; $display("FAIL full_ps k=%0d ps=%b expected=%b", k, period_start, e.ps); end
        end
    endtask

    // Mid-cycle loads (last wins), applied at wrap; load at wrap applies directly.
    task automatic test_update();
        logic [CH-1:0] eo;
        int d0;
        do_reset();
        direct_load(8'd9, {8'd5, 8'd255, 8'd0, 8'd3});
        ena = 1'b1; step = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            load = (k == 5) || (k == 7) || (k == 20);
            if (k == 5)  duty[7:0] = 8'd6;
            if (k == 7)  duty[7:0] = 8'd7;
            if (k == 20) duty[7:0] = 8'd2;
            d0 = (k <= 10) ? 3 : ((k <= 20) ? 7 : 2);
            eo = {(((k-1) % 10) < 5), 1'b1, 1'b0, (((k-1) % 10) < d0)};
            push(eo, (k % 10) == 0, (k >= 5) && (k <= 9), 1'b1);
            tick();
            load = 1'b0;
            e = sb.pop_front();
            $display("update k=%0d out=%b ps=%b up=%b", k, out, period_start, update_pending);
            total++; if (out !== e.o) begin bad++; $display("FAIL update_out k=%0d out=%b expected=%b", k, out, e.o); end
            total++; if (period_start !== e.ps) begin bad++; $display("FAIL update_ps k=%0d ps=%b expected=%b", k, period_start, e.ps); end
            total++; if (update_pending !== e.up) begin bad++; $display("FAIL update_up k=%0d up=%b expected=%b", k, update_pending, e.up); end
        end
    endtask

    // ena dropped mid-cycle and step gaps: counter freezes and resumes.
    task automatic test_ena_step();
        logic [CH-1:0] eo;
        int c = 0;
        logic en_k, st_k;
        do_reset();
        direct_load(8'd9, {8'd5, 8'd255, 8'd0, 8'd8});
        for (int k = 1; k <= 30; k++) begin
            en_k = !((k >= 7) && (k <= 9));
            st_k = !((k == 15) || (k == 16));
            ena = en_k; step = st_k;
            eo = en_k ? {((c % 10) < 5), 1'b1, 1'b0, ((c % 10) < 8)} : 4'b0000;
            push(eo, en_k && st_k && ((c % 10) == 9), 1'b0, 1'b1);
            if (en_k && st_k) c++;
            tick();
            e = sb.pop_front();
            $display("enastep k=%0d ena=%b step=%b out=%b ps=%b", k, en_k, st_k, out, period_start);
            total++; if (out !== e.o) begin bad++; $display("FAIL enastep_out k=%0d out=%b expected=%b", k, out, e.o); end
            total++; if (period_start !== e.ps) begin bad++; $display("FAIL enastep_ps k=%0d ps=%b expected=%b", k, period_start, e.ps); end
            total++; if (update_pending !== e.up) begin bad++; $display("FAIL enastep_up k=%0d up=%b expected=%b", k, update_pending, e.up); end
        end
    endtask

    // Async reset at counter 6 with a pending load.
    task automatic test_async_reset();
        logic [CH-1:0] eo;
        do_reset();
        direct_load(8'd9, {8'd5, 8'd255, 8'd0, 8'd3});
        ena = 1'b1; step = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            load = (k == 5);
            if (k == 5) duty[7:0] = 8'd7;
            tick();
            load = 1'b0;
        end
        push(4'b0100, 1'b0, 1'b1, 1'b0);
        e = sb.pop_front();
        total++; if (out !== e.o) begin bad++; $display("FAIL prereset_out out=%b expected=%b", out, e.o); end
        total++; if (update_pending !== e.up) begin bad++; $display("FAIL prereset_up up=%b expected=%b", update_pending, e.up); end
        #2 rst = 1'b0;
        #1;
        push(4'b0000, 1'b0, 1'b0, 1'b1);
        e = sb.pop_front();
        $display("async_reset: out=%b ps=%b up=%b", out, period_start, update_pending);
        total++; if (out !== e.o) begin bad++; $display("FAIL areset_out out=%b expected=%b", out, e.o); end
        total++; if (period_start !== e.ps) begin bad++; $display("FAIL areset_ps ps=%b expected=%b", period_start, e.ps); end
        total++; if (update_pending !== e.up) begin bad++; $display("FAIL areset_up up=%b expected=%b", update_pending, e.up); end
        #1 rst = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            push(4'b0000, 1'b0, 1'b0, 1'b0);
            tick();
            e = sb.pop_front();
            $display("postreset k=%0d out=%b up=%b", k, out, update_pending);
            total++; if (out !== e.o) begin bad++; $display("FAIL postreset_out k=%0d out=%b expected=%b", k, out, e.o); end
            total++; if (update_pending !== e.up) begin bad++; $display("FAIL postreset_up k=%0d up=%b expected=%b", k, update_pending, e.up); end
        end
        direct_load(8'd9, {8'd5, 8'd255, 8'd0, 8'd3});
        ena = 1'b1; step = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            eo = {((k-1) < 5), 1'b1, 1'b0, ((k-1) < 3)};
            push(eo, k == 10, 1'b0, 1'b1);
            tick();
            e = sb.pop_front();
            $display("restart k=%0d out=%b ps=%b", k, out, period_start);
            total++; if (out !== e.o) begin bad++; $display("FAIL restart_out k=%0d out=%b expected=%b", k, out, e.o); end
            total++; if (period_start !== e.ps) begin bad++; $display("FAIL restart_ps k=%0d ps=%b expected=%b", k, period_start, e.ps); end
        end
    endtask

`ifdef PWM_CENTER_ALIGN_EN
    // period 4, center: counter 0,1,2,3,4,3,2,1 repeating.
    task automatic test_center();
        int seq [8] = '{0, 1, 2, 3, 4, 3, 2, 1};
        int cv;
        logic [CH-1:0] eo;
        do_reset();
        center = 1'b1;
        direct_load(8'd4, {8'd255, 8'd0, 8'd3, 8'd2});
        ena = 1'b1; step = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            cv = seq[(k-1) % 8];
            eo = {1'b1, 1'b0, (cv < 3), (cv < 2)};
            push(eo, ((k-1) % 8) == 7, 1'b0, 1'b1);
            tick();
            e = sb.pop_front();
            $display("center k=%0d out=%b ps=%b", k, out, period_start);
            total++; if (out !== e.o) begin bad++; $display("FAIL center_out k=%0d out=%b expected=%b", k, out, e.o); end
            total++; if (period_start !== e.ps) begin bad++; $display("FAIL center_ps k=%0d ps=%b expected=%b", k, period_start, e.ps); end
        end
        center = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_edge_basic();
        test_full_scale();
        test_update();
        test_ena_step();
        test_async_reset();
`ifdef PWM_CENTER_ALIGN_EN
        test_center();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
